// File: rtl/arena_frame_ctrl.sv
// Double-buffered 4x4 arena frame controller: back-buffer pixel writes, tear-free
// commit at scan-frame boundaries, frame-synchronous blink and frame timing pulses.
module arena_frame_ctrl #(
    parameter int unsigned BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic        wr_data,
    input  logic        clr,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic        blink_en,
    output logic [15:0] arena_on,
    output logic        swap_done,
    output logic        frame_tick,
    output logic [7:0]  frame_cnt
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic {
        IDLE,
        PENDING
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  scan_q, scan_d;
    logic [15:0] front_q, front_d;
    logic [15:0] back_q, back_d;
    logic [15:0] arena_q, arena_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        visible_q, visible_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        swap_done_q, swap_done_d;
    logic        frame_tick_q, frame_tick_d;

    logic        boundary;
    logic        wr_fire;
    logic        commit_fire;

    always_comb begin
        state_d      = state_q;
        scan_d       = scan_q + 4'd1;
        front_d      = front_q;
        back_d       = back_q;
        arena_d      = arena_q;
        blink_cnt_d  = blink_cnt_q;
        visible_d    = visible_q;
        frame_cnt_d  = frame_cnt_q;
        swap_done_d  = 1'b0;

        boundary     = (scan_q == 4'd15);
        frame_tick_d = boundary;
        wr_ready     = (state_q == IDLE);
        commit_ready = (state_q == IDLE);
        wr_fire      = wr_valid && wr_ready;
        commit_fire  = commit_valid && commit_ready;

        // Clear first so a same-cycle write overrides its own bit.
        if (clr && wr_ready) begin
            back_d = '0;
        end
        if (wr_fire) begin
            back_d[wr_addr] = wr_data;
        end

        // A commit accepted in a boundary cycle waits for the following boundary.
        case (state_q)
            IDLE: begin
                if (commit_fire) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    front_d     = back_q;
                    swap_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (!blink_en) begin
                blink_cnt_d = '0;
                visible_d   = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
            arena_d = front_d & {16{visible_d}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            front_q      <= '0;
            back_q       <= '0;
            arena_q      <= '0;
            blink_cnt_q  <= '0;
            visible_q    <= 1'b1;
            frame_cnt_q  <= '0;
            swap_done_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            front_q      <= front_d;
            back_q       <= back_d;
            arena_q      <= arena_d;
            blink_cnt_q  <= blink_cnt_d;
            visible_q    <= visible_d;
            frame_cnt_q  <= frame_cnt_d;
            swap_done_q  <= swap_done_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign arena_on   = arena_q;
    assign swap_done  = swap_done_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_arena_frame_ctrl.sv
// Directed self-checking bench for arena_frame_ctrl (BLINK_FRAMES=2); the bench
// tracks the scan position and frame count itself.
module tb_arena_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic        wr_data;
    logic        clr;
    logic        commit_valid;
    logic        commit_ready;
    logic        blink_en;
    logic [15:0] arena_on;
    logic        swap_done;
    logic        frame_tick;
    logic [7:0]  frame_cnt;

    int          checks;
    int          errors;
    logic [3:0]  scan_m;
    logic [7:0]  frame_m;
    logic [15:0] pat;

    arena_frame_ctrl #(.BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clr          (clr),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .blink_en     (blink_en),
        .arena_on     (arena_on),
        .swap_done    (swap_done),
        .frame_tick   (frame_tick),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (scan_m == 4'd15) frame_m = frame_m + 8'd1;
            scan_m = scan_m + 4'd1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        scan_m = '0;
        frame_m = '0;
        pat = 16'hA5A5;
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = 1'b0;
        clr = 1'b0;
        commit_valid = 1'b0;
        blink_en = 1'b0;

        step(3);
        chk("rst_arena", arena_on, 16'h0000);
        chk("rst_wr_ready", 16'(wr_ready), 16'h1);
        chk("rst_commit_ready", 16'(commit_ready), 16'h1);
        chk("rst_frame_cnt", 16'(frame_cnt), 16'h0);
        chk("rst_swap_done", 16'(swap_done), 16'h0);
        chk("rst_frame_tick", 16'(frame_tick), 16'h0);
        rst = 1'b0;
        scan_m = '0;
        frame_m = '0;

        // Write pixels 0..3, commit at scan 5
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i); wr_data = 1'b1;
            step(1);
        end
        wr_valid = 1'b0;
        step(1);
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        chk("pend_commit_ready", 16'(commit_ready), 16'h0);
        chk("pend_wr_ready", 16'(wr_ready), 16'h0);
        chk("pend_arena", arena_on, 16'h0000);
        step(9);
        chk("pend_arena_s15", arena_on, 16'h0000);
        chk("pend_swap_s15", 16'(swap_done), 16'h0);
        step(1);
        chk("swap1_arena", arena_on, 16'h000F);
        chk("swap1_done", 16'(swap_done), 16'h1);
        chk("swap1_tick", 16'(frame_tick), 16'h1);
        chk("swap1_wr_ready", 16'(wr_ready), 16'h1);
        chk("swap1_commit_ready", 16'(commit_ready), 16'h1);
        chk("swap1_frame_cnt", 16'(frame_cnt), 16'(frame_m));
        step(1);
        chk("swap1_done_once", 16'(swap_done), 16'h0);
        chk("tick_once", 16'(frame_tick), 16'h0);

        // Write blocked while pending; recommit keeps back contents
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 1'b1;
        chk("blocked_wr_ready", 16'(wr_ready), 16'h0);
        step(1);
        wr_valid = 1'b0;
        step(13);
        chk("recommit_arena", arena_on, 16'h000F);
        chk("recommit_done", 16'(swap_done), 16'h1);

        // Commit with write exactly at the boundary
        step(15);
        commit_valid = 1'b1; wr_valid = 1'b1; wr_addr = 4'd8; wr_data = 1'b1;
        step(1);
        commit_valid = 1'b0; wr_valid = 1'b0;
        chk("bnd_no_swap_arena", arena_on, 16'h000F);
        chk("bnd_no_swap_done", 16'(swap_done), 16'h0);
        chk("bnd_commit_ready", 16'(commit_ready), 16'h0);
        step(15);
        chk("bnd_arena_s15", arena_on, 16'h000F);
        step(1);
        chk("bnd_swap_arena", arena_on, 16'h010F);
        chk("bnd_swap_done", 16'(swap_done), 16'h1);

        // Clear with a simultaneous write
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 4'd4; wr_data = 1'b1;
        step(1);
        clr = 1'b0; wr_valid = 1'b0;
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        step(14);
        chk("clr_write_arena", arena_on, 16'h0010);

        // Blink with BLINK_FRAMES=2
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_addr = 4'(i); wr_data = pat[i];
            step(1);
        end
        wr_valid = 1'b0;
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        step(15);
        chk("blink_front", arena_on, 16'hA5A5);
        blink_en = 1'b1;
        step(16);
        chk("blink_on_f2", arena_on, 16'hA5A5);
        step(16);
        chk("blink_off_f1", arena_on, 16'h0000);
        step(15);
        chk("blink_off_s15", arena_on, 16'h0000);
        step(1);
        chk("blink_off_f2", arena_on, 16'h0000);
        step(16);
        chk("blink_on2_f1", arena_on, 16'hA5A5);
        step(15);
        chk("blink_on2_s15", arena_on, 16'hA5A5);
        step(1);
        chk("blink_on2_f2", arena_on, 16'hA5A5);
        step(16);
        chk("blink_off2_f1", arena_on, 16'h0000);
        step(5);
        blink_en = 1'b0;
        step(10);
        chk("unblink_s15", arena_on, 16'h0000);
        step(1);
        chk("unblink_restore", arena_on, 16'hA5A5);
        chk("frame_cnt_run", 16'(frame_cnt), 16'(frame_m));

        // Reset while pending drops the commit and both buffers
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        chk("rst2_pending", 16'(commit_ready), 16'h0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        scan_m = '0;
        frame_m = '0;
        chk("rst2_arena", arena_on, 16'h0000);
        chk("rst2_commit_ready", 16'(commit_ready), 16'h1);
        chk("rst2_frame_cnt", 16'(frame_cnt), 16'h0);
        step(16);
        chk("rst2_no_swap", 16'(swap_done), 16'h0);
        chk("rst2_front_cleared", arena_on, 16'h0000);
        chk("rst2_frame_cnt_1", 16'(frame_cnt), 16'(frame_m));
        commit_valid = 1'b1;
        step(1);
        commit_valid = 1'b0;
        step(15);
        chk("rst2_back_cleared", arena_on, 16'h0000);
        chk("rst2_swap_done", 16'(swap_done), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
